// File: rtl/shift_right_4_add_inv_pkg.sv
// Shared definitions for the x + (x >>> SHIFT) inverse scaler.
//   DATA_W        : sample width
//   DEFAULT_SHIFT : default shift of the forward scaler being inverted
//   state_t       : FSM state encoding (visible to benches for decode)
//   sat_to_data   : clamp a DATA_W+1 signed value into DATA_W bits
package shift_right_4_add_inv_pkg;

  localparam int unsigned DATA_W        = 32;
  localparam int unsigned DEFAULT_SHIFT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  // Saturate a one-bit-wider signed result back into DATA_W bits.
  function automatic logic signed [DATA_W-1:0] sat_to_data(input logic signed [DATA_W:0] v);
    logic signed [DATA_W-1:0] r;
    if (v[DATA_W] != v[DATA_W-1]) begin
      r = v[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      r = v[DATA_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_right_4_add_inv_step.sv
// One contraction step of the inverse scaler, purely combinational.
//   x_i      : captured target sample
//   y_i      : current iterate
//   y_next_c : sat(x - (y >>> SHIFT))
//   exact_c  : sat(y_next + (y_next >>> SHIFT)) == x
module shift_right_4_add_inv_step
  import shift_right_4_add_inv_pkg::*;
#(
  parameter int unsigned SHIFT = DEFAULT_SHIFT
) (
  input  logic [DATA_W-1:0] x_i,
  input  logic [DATA_W-1:0] y_i,
  output logic [DATA_W-1:0] y_next_c,
  output logic              exact_c
);

  logic signed [DATA_W-1:0] x_s;
  logic signed [DATA_W-1:0] y_s;
  logic signed [DATA_W-1:0] shr_y;
  logic signed [DATA_W-1:0] y_nxt;
  logic signed [DATA_W-1:0] shr_nxt;
  logic signed [DATA_W:0]   diff;
  logic signed [DATA_W:0]   sum;
  logic signed [DATA_W-1:0] fwd;

  // Arithmetic shifts keep negative samples on the floor side (no rounding to zero).
  always_comb begin
    x_s     = $signed(x_i);
    y_s     = $signed(y_i);
    shr_y   = y_s >>> SHIFT;
    diff    = $signed({x_s[DATA_W-1], x_s}) - $signed({shr_y[DATA_W-1], shr_y});
    y_nxt   = sat_to_data(diff);
    shr_nxt = y_nxt >>> SHIFT;
    sum     = $signed({y_nxt[DATA_W-1], y_nxt}) + $signed({shr_nxt[DATA_W-1], shr_nxt});
    fwd     = sat_to_data(sum);
    y_next_c = y_nxt;
    exact_c  = (fwd == x_s);
  end

endmodule

// File: rtl/shift_right_4_add_inv.sv
// Iterative inverse of the forward pre-scaler y + (y >>> SHIFT).
// Runs y <- x - (y >>> SHIFT) from y = x until it stops changing or the
// iteration cap is hit, then presents the result with valid/ready.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake, data_i = signed sample x
//   out_valid/out_ready : output handshake
//   data_o              : result y
//   exact_o             : y is an exact preimage of x
//   iter_o              : update cycles used (1..MAX_ITER)
module shift_right_4_add_inv
  import shift_right_4_add_inv_pkg::*;
#(
  parameter int unsigned SHIFT    = DEFAULT_SHIFT,
  parameter int unsigned MAX_ITER = 8,
  parameter int unsigned ITER_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_o,
  output logic              exact_o,
  output logic [ITER_W-1:0] iter_o
);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   x_q, x_d;
  logic [DATA_W-1:0]   y_q, y_d;
  logic [ITER_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                exact_q, exact_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;

  logic [DATA_W-1:0]   y_next_c;
  logic                exact_c;
  logic                converged_c;
  logic                cap_c;

  shift_right_4_add_inv_step #(
    .SHIFT (SHIFT)
  ) u_step (
    .x_i      (x_q),
    .y_i      (y_q),
    .y_next_c (y_next_c),
    .exact_c  (exact_c)
  );

  assign converged_c = (y_next_c == y_q);
  assign cap_c       = (cnt_q == ITER_W'(MAX_ITER - 1));

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      exact_q     <= 1'b0;
      iter_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      exact_q     <= exact_d;
      iter_q      <= iter_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state logic; handshake flags are registered from the next state.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    exact_d     = exact_q;
    iter_d      = iter_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d        = data_i;
          y_d        = data_i;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = ITER;
        end
      end
      ITER: begin
        y_d   = y_next_c;
        cnt_d = cnt_q + ITER_W'(1);
        // Strict equality: x=0 converges on the first update.
        if (converged_c || cap_c) begin
          data_d      = y_next_c;
          iter_d      = cnt_q + ITER_W'(1);
          exact_d     = exact_c;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        // No same-cycle re-accept: in_ready rises only once back in IDLE.
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign data_o    = data_q;
  assign exact_o   = exact_q;
  assign iter_o    = iter_q;

endmodule

// File: tb/tb_shift_right_4_add_inv.sv
// Directed bench for shift_right_4_add_inv (SHIFT=4, MAX_ITER=8).
module tb_shift_right_4_add_inv;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_i;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_o;
  logic        exact_o;
  logic [3:0]  iter_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shift_right_4_add_inv dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_i    (data_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_o    (data_o),
    .exact_o   (exact_o),
    .iter_o    (iter_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Accept x, wait for the result, check it and the latency, then drain it.
  task automatic run(input string tag, input logic [31:0] x, input logic [31:0] exp_y,
                     input int exp_iter, input logic exp_exact);
    int n;
    check({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
    data_i   = x;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_latency"}, 32'(n), 32'(exp_iter));
    check({tag, "_data"}, data_o, exp_y);
    check({tag, "_iter"}, 32'(iter_o), 32'(exp_iter));
    check({tag, "_exact"}, 32'(exact_o), 32'(exp_exact));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_data"}, data_o, 32'd0);
    check({tag, "_iter"}, 32'(iter_o), 32'd0);
    check({tag, "_exact"}, 32'(exact_o), 32'd0);
  endtask

  initial begin
    int n;
    logic [31:0] held;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data_i    = '0;
    tick();
    tick();
    rst = 1'b0;
    check_reset_outputs("reset");

    run("x17",  32'd17,   32'd16,   2, 1'b1);
    run("x1600", 32'd1600, 32'd1506, 4, 1'b1);
    run("xm17", -32'sd17, -32'sd16, 3, 1'b1);
    run("x0",   32'd0,    32'd0,    1, 1'b1);
    run("x16",  32'd16,   32'd16,   8, 1'b0);

    // Backpressure in DONE with in_valid noise.
    data_i   = 32'd1600;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check("bp_reach_done", 32'(out_valid), 32'd1);
    held = data_o;
    check("bp_data_first", held, 32'd1506);
    for (int i = 0; i < 5; i++) begin
      data_i   = 32'd99;
      in_valid = (i % 2) == 0;
      tick();
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_data_hold", data_o, 32'd1506);
      check("bp_iter_hold", 32'(iter_o), 32'd4);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_released", 32'(out_valid), 32'd0);
    run("bp_next", 32'd17, 32'd16, 2, 1'b1);

    // Reset mid-iteration after two updates.
    data_i   = 32'd1600;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("rst_iter_pre", 32'(out_valid), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("rst_iter");
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rst_iter_no_stray", 32'(out_valid), 32'd0);
    end

    // Reset while holding a result in DONE.
    data_i   = 32'd17;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("rst_done_pre", 32'(out_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("rst_done");
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_done_no_stray", 32'(out_valid), 32'd0);
    end

    run("post_rst", -32'sd17, -32'sd16, 3, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
